// File: rtl/convolution_procesor_addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// convolution_procesor_addsub_pipe_if
// Handshake bundle for the pipelined add/sub unit.
//   Input side : in_valid, in_ready, op_sub, re_A, re_B
//   Output side: out_valid, out_ready, re_out, ovf
// modport slave  : the add/sub unit itself
// modport master : whoever feeds operands and consumes results
// ---------------------------------------------------------------------------
interface convolution_procesor_addsub_pipe_if #(
  parameter int DATA_WIDTH_A = 22,
  parameter int DATA_WIDTH_B = 22,
  parameter int DATA_WIDTH_O = 22
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    op_sub;
  logic [DATA_WIDTH_A-1:0] re_A;
  logic [DATA_WIDTH_B-1:0] re_B;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH_O-1:0] re_out;
  logic                    ovf;

  modport slave (
    input  in_valid, op_sub, re_A, re_B, out_ready,
    output in_ready, out_valid, re_out, ovf
  );

  modport master (
    output in_valid, op_sub, re_A, re_B, out_ready,
    input  in_ready, out_valid, re_out, ovf
  );
endinterface

// File: rtl/convolution_procesor_addsub_pipe.sv
// ---------------------------------------------------------------------------
// convolution_procesor_addsub_pipe
// Pipelined signed add/subtract with valid/ready flow control, per-beat
// add/sub select and saturate-or-wrap overflow handling.
//   clk        : clock, rising edge
//   rst_a      : asynchronous reset, active low
//   clear      : synchronous flush of all in-flight beats (data kept)
//   ovf_clr    : synchronous clear of ovf_sticky
//   ovf_sticky : set by any transferred beat that overflowed
//   bus        : operand/result handshake (slave modport)
// The whole computation happens before the first register; the remaining
// stages only carry data. Every stage moves together when the output slot
// is empty or being drained, so bubbles are kept, not compressed.
// ---------------------------------------------------------------------------
module convolution_procesor_addsub_pipe #(
  parameter int DATA_WIDTH_A = 22,
  parameter int DATA_WIDTH_B = 22,
  parameter int DATA_WIDTH_O = 22,
  parameter int PIPE_STAGES  = 2,
  parameter bit SATURATE     = 1'b1
) (
  input  logic clk,
  input  logic rst_a,
  input  logic clear,
  input  logic ovf_clr,
  output logic ovf_sticky,
  convolution_procesor_addsub_pipe_if.slave bus
);

  localparam int MAX_AB = (DATA_WIDTH_A > DATA_WIDTH_B) ? DATA_WIDTH_A : DATA_WIDTH_B;
  // One guard bit above the widest operand/result keeps A +/- B exact.
  localparam int W      = ((MAX_AB > DATA_WIDTH_O) ? MAX_AB : DATA_WIDTH_O) + 1;
  localparam int LAST   = PIPE_STAGES - 1;

  // Fold an exact W-bit result into DATA_WIDTH_O bits; returns {ovf, value}.
  // The result fits when every bit from the sign position of the narrow
  // result upwards is a copy of that sign bit.
  function automatic logic [DATA_WIDTH_O:0] fit_result(input logic [W-1:0] r);
    logic                    fits;
    logic [DATA_WIDTH_O-1:0] val;
    fits = (r[W-1:DATA_WIDTH_O-1] == {(W-DATA_WIDTH_O+1){r[DATA_WIDTH_O-1]}});
    if (fits) begin
      val = r[DATA_WIDTH_O-1:0];
    end else if (SATURATE) begin
      val = r[W-1] ? {1'b1, {(DATA_WIDTH_O-1){1'b0}}}
                   : {1'b0, {(DATA_WIDTH_O-1){1'b1}}};
    end else begin
      val = r[DATA_WIDTH_O-1:0];
    end
    return {~fits, val};
  endfunction

  logic [W-1:0]            a_ext_s;
  logic [W-1:0]            b_ext_s;
  logic [W-1:0]            r_s;
  logic [DATA_WIDTH_O:0]   fit_s;
  logic                    advance_s;
  logic                    xfer_ovf_s;

  logic [PIPE_STAGES-1:0]  vld_r;
  logic [PIPE_STAGES-1:0]  ovf_r;
  logic [DATA_WIDTH_O-1:0] dat_r [PIPE_STAGES];
  logic                    ovf_sticky_r;

  assign a_ext_s = {{(W-DATA_WIDTH_A){bus.re_A[DATA_WIDTH_A-1]}}, bus.re_A};
  assign b_ext_s = {{(W-DATA_WIDTH_B){bus.re_B[DATA_WIDTH_B-1]}}, bus.re_B};

  // Exact sum/difference and its fold into the output width.
  always_comb begin
    r_s   = a_ext_s + b_ext_s;
    if (bus.op_sub) begin
      r_s = a_ext_s - b_ext_s;
    end else begin
      r_s = a_ext_s + b_ext_s;
    end
    fit_s = fit_result(r_s);
  end

  // The pipe moves as a whole when the output slot is empty or draining.
  assign advance_s    = ~vld_r[LAST] | bus.out_ready;
  assign bus.in_ready = advance_s;

  // An overflowing beat actually handed to the consumer this cycle.
  assign xfer_ovf_s   = vld_r[LAST] & bus.out_ready & ovf_r[LAST];

  // Stage valid bits: flushed by clear, shifted on advance, held otherwise.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      vld_r <= '0;
    end else if (clear) begin
      vld_r <= '0;
    end else if (advance_s) begin
      vld_r[0] <= bus.in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end else begin
      vld_r <= vld_r;
    end
  end

  // Stage data and per-beat overflow flags; untouched by clear.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      ovf_r <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        dat_r[i] <= '0;
      end
    end else if (!clear && advance_s) begin
      dat_r[0] <= fit_s[DATA_WIDTH_O-1:0];
      ovf_r[0] <= fit_s[DATA_WIDTH_O];
      for (int i = 1; i < PIPE_STAGES; i++) begin
        dat_r[i] <= dat_r[i-1];
        ovf_r[i] <= ovf_r[i-1];
      end
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Sticky overflow: a transferred overflow beat wins over ovf_clr.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      ovf_sticky_r <= 1'b0;
    end else if (xfer_ovf_s) begin
      ovf_sticky_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_r <= 1'b0;
    end else begin
      ovf_sticky_r <= ovf_sticky_r;
    end
  end

  assign bus.out_valid = vld_r[LAST];
  assign bus.re_out    = dat_r[LAST];
  assign bus.ovf       = ovf_r[LAST];
  assign ovf_sticky    = ovf_sticky_r;

endmodule

// File: tb/tb_convolution_procesor_addsub_pipe.sv
// ---------------------------------------------------------------------------
// Bench for convolution_procesor_addsub_pipe.
//   dut_m : A=B=O=8, 2 stages, saturate (main instance, checked every cycle
//           against a queue-based model of the pipe)
//   dut_w : A=B=O=8, 3 stages, wrap
//   dut_x : A=8, B=4, O=10, 1 stage, saturate
// ---------------------------------------------------------------------------
module tb_convolution_procesor_addsub_pipe;

  localparam int P_M = 2;

  logic clk;
  logic rst_a;
  logic clear_m, ovf_clr_m, sticky_m;
  logic clear_w, ovf_clr_w, sticky_w;
  logic clear_x, ovf_clr_x, sticky_x;

  int checks   = 0;
  int failures = 0;

  convolution_procesor_addsub_pipe_if #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .DATA_WIDTH_O(8))  bus_m ();
  convolution_procesor_addsub_pipe_if #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .DATA_WIDTH_O(8))  bus_w ();
  convolution_procesor_addsub_pipe_if #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(4), .DATA_WIDTH_O(10)) bus_x ();

  convolution_procesor_addsub_pipe #(
    .DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .DATA_WIDTH_O(8), .PIPE_STAGES(P_M), .SATURATE(1'b1)
  ) dut_m (
    .clk(clk), .rst_a(rst_a), .clear(clear_m), .ovf_clr(ovf_clr_m), .ovf_sticky(sticky_m), .bus(bus_m)
  );

  convolution_procesor_addsub_pipe #(
    .DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .DATA_WIDTH_O(8), .PIPE_STAGES(3), .SATURATE(1'b0)
  ) dut_w (
    .clk(clk), .rst_a(rst_a), .clear(clear_w), .ovf_clr(ovf_clr_w), .ovf_sticky(sticky_w), .bus(bus_w)
  );

  convolution_procesor_addsub_pipe #(
    .DATA_WIDTH_A(8), .DATA_WIDTH_B(4), .DATA_WIDTH_O(10), .PIPE_STAGES(1), .SATURATE(1'b1)
  ) dut_x (
    .clk(clk), .rst_a(rst_a), .clear(clear_x), .ovf_clr(ovf_clr_x), .ovf_sticky(sticky_x), .bus(bus_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the rules: exact integer result, then
  // clamp or wrap into an ow-bit signed range.
  function automatic void model(input int a, input int b, input bit sub, input int ow,
                                input bit sat, output int res, output bit ov);
    int r, mx, mn;
    r  = sub ? a - b : a + b;
    mx = (1 << (ow - 1)) - 1;
    mn = -(1 << (ow - 1));
    if (r > mx || r < mn) begin
      ov = 1'b1;
      if (sat) begin
        res = (r > mx) ? mx : mn;
      end else begin
        res = r & ((1 << ow) - 1);
        if (res > mx) res = res - (1 << ow);
      end
    end else begin
      ov  = 1'b0;
      res = r;
    end
  endfunction

  // ---------------- model of dut_m + per-cycle compare ----------------
  typedef struct { bit v; int d; bit o; } slot_t;
  slot_t pipe[$];
  bit    sticky_e;
  int    got[$];

  always @(negedge clk) begin
    slot_t s;
    int    res;
    bit    ov;
    if (!rst_a) begin
      pipe.delete();
      s = '{v: 1'b0, d: 0, o: 1'b0};
      repeat (P_M) pipe.push_back(s);
      sticky_e = 1'b0;
      chk("rst_out_valid", int'(bus_m.out_valid), 0);
      chk("rst_sticky",    int'(sticky_m), 0);
      chk("rst_in_ready",  int'(bus_m.in_ready), 1);
    end else begin
      chk("out_valid", int'(bus_m.out_valid), int'(pipe[P_M-1].v));
      if (pipe[P_M-1].v) begin
        chk("re_out", int'($signed(bus_m.re_out)), pipe[P_M-1].d);
        chk("ovf",    int'(bus_m.ovf), int'(pipe[P_M-1].o));
      end
      chk("in_ready", int'(bus_m.in_ready), int'(!pipe[P_M-1].v || bus_m.out_ready));
      chk("sticky",   int'(sticky_m), int'(sticky_e));
      // predict the coming edge
      if (pipe[P_M-1].v && bus_m.out_ready) begin
        got.push_back(int'($signed(bus_m.re_out)));
        if (pipe[P_M-1].o) sticky_e = 1'b1;
        else if (ovf_clr_m) sticky_e = 1'b0;
      end else if (ovf_clr_m) begin
        sticky_e = 1'b0;
      end
      if (clear_m) begin
        for (int i = 0; i < P_M; i++) pipe[i].v = 1'b0;
      end else if (!pipe[P_M-1].v || bus_m.out_ready) begin
        model(int'($signed(bus_m.re_A)), int'($signed(bus_m.re_B)), bus_m.op_sub, 8, 1'b1, res, ov);
        s = '{v: bus_m.in_valid, d: res, o: ov};
        void'(pipe.pop_back());
        pipe.push_front(s);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input bit v, input int a, input int b, input bit s);
    bus_m.in_valid = v;
    bus_m.re_A     = 8'(a);
    bus_m.re_B     = 8'(b);
    bus_m.op_sub   = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit acc;
    int va[4];
    rst_a = 1'b0;
    clear_m = 1'b0; ovf_clr_m = 1'b0;
    clear_w = 1'b0; ovf_clr_w = 1'b0;
    clear_x = 1'b0; ovf_clr_x = 1'b0;
    drive_m(1'b0, 0, 0, 1'b0);
    bus_m.out_ready = 1'b1;
    bus_w.in_valid = 1'b0; bus_w.op_sub = 1'b0; bus_w.re_A = 8'd0; bus_w.re_B = 8'd0; bus_w.out_ready = 1'b1;
    bus_x.in_valid = 1'b0; bus_x.op_sub = 1'b0; bus_x.re_A = 8'd0; bus_x.re_B = 4'd0; bus_x.out_ready = 1'b1;
    #1;
    chk("reset_re_out", int'(bus_m.re_out), 0);
    chk("reset_ovf",    int'(bus_m.ovf), 0);
    chk("reset_in_rdy", int'(bus_m.in_ready), 1);
    tick(); tick();
    rst_a = 1'b1;
    tick();

    // wrap instance, 3 stages: 127+1 -> 0x80, -128-1 -> 0x7F, both overflow
    bus_w.in_valid = 1'b1; bus_w.re_A = 8'sd127; bus_w.re_B = 8'sd1; bus_w.op_sub = 1'b0;
    tick();
    bus_w.re_A = 8'h80; bus_w.re_B = 8'sd1; bus_w.op_sub = 1'b1;
    tick();
    bus_w.in_valid = 1'b0;
    chk("wrap_latency_early", int'(bus_w.out_valid), 0);
    tick();
    chk("wrap_valid1", int'(bus_w.out_valid), 1);
    chk("wrap_out1",   int'(bus_w.re_out), 8'h80);
    chk("wrap_ovf1",   int'(bus_w.ovf), 1);
    tick();
    chk("wrap_out2",   int'(bus_w.re_out), 8'h7F);
    chk("wrap_ovf2",   int'(bus_w.ovf), 1);
    tick();
    chk("wrap_drained", int'(bus_w.out_valid), 0);
    chk("wrap_sticky",  int'(sticky_w), 1);

    // mixed widths, 1 stage: -128-7 = -135, 100-(-8) = 108
    bus_x.in_valid = 1'b1; bus_x.re_A = 8'h80; bus_x.re_B = 4'd7; bus_x.op_sub = 1'b1;
    tick();
    chk("mix_valid1", int'(bus_x.out_valid), 1);
    chk("mix_out1",   int'($signed(bus_x.re_out)), -135);
    chk("mix_ovf1",   int'(bus_x.ovf), 0);
    bus_x.re_A = 8'sd100; bus_x.re_B = 4'b1000;
    tick();
    chk("mix_out2",   int'($signed(bus_x.re_out)), 108);
    chk("mix_ovf2",   int'(bus_x.ovf), 0);
    bus_x.in_valid = 1'b0;
    tick();
    chk("mix_drained", int'(bus_x.out_valid), 0);

    // main: 100+27 = 127, one edge after acceptance
    drive_m(1'b1, 100, 27, 1'b0);
    tick();
    drive_m(1'b0, 0, 0, 1'b0);
    tick();
    chk("add_valid", int'(bus_m.out_valid), 1);
    chk("add_out",   int'($signed(bus_m.re_out)), 127);
    chk("add_ovf",   int'(bus_m.ovf), 0);

    // saturate: -128-1 -> -128 with ovf, sticky after transfer
    drive_m(1'b1, -128, 1, 1'b1);
    tick();
    drive_m(1'b0, 0, 0, 1'b0);
    tick();
    chk("sat_out", int'($signed(bus_m.re_out)), -128);
    chk("sat_ovf", int'(bus_m.ovf), 1);
    tick();
    chk("sat_sticky", int'(sticky_m), 1);
    ovf_clr_m = 1'b1;
    tick();
    ovf_clr_m = 1'b0;
    chk("sticky_cleared", int'(sticky_m), 0);
    tick();

    // backpressure: 1+1..4+4 with a 3-cycle stall
    got.delete();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      bus_m.out_ready = !(c >= 2 && c < 5);
      if (idx < 4) drive_m(1'b1, idx + 1, idx + 1, 1'b0);
      else         drive_m(1'b0, 0, 0, 1'b0);
      #1;
      if (bus_m.out_valid && !bus_m.out_ready) chk("stall_in_ready", int'(bus_m.in_ready), 0);
      acc = bus_m.in_valid && bus_m.in_ready;
      tick();
      if (acc) idx++;
    end
    bus_m.out_ready = 1'b1;
    drive_m(1'b0, 0, 0, 1'b0);
    va[0] = 2; va[1] = 4; va[2] = 6; va[3] = 8;
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("bp_order", got[i], va[i]);
    end

    // reset mid-stream: sticky set first, then two beats in flight
    drive_m(1'b1, 127, 1, 1'b0);
    tick();
    drive_m(1'b0, 0, 0, 1'b0);
    tick(); tick();
    chk("pre_rst_sticky", int'(sticky_m), 1);
    drive_m(1'b1, 10, 1, 1'b0);
    tick();
    drive_m(1'b1, 20, 2, 1'b0);
    tick();
    drive_m(1'b0, 0, 0, 1'b0);
    rst_a = 1'b0;
    #1;
    chk("rst_drop_valid",  int'(bus_m.out_valid), 0);
    chk("rst_drop_sticky", int'(sticky_m), 0);
    tick();
    rst_a = 1'b1;
    drive_m(1'b1, 5, 6, 1'b0);
    tick();
    drive_m(1'b0, 0, 0, 1'b0);
    tick();
    chk("post_rst_valid", int'(bus_m.out_valid), 1);
    chk("post_rst_out",   int'($signed(bus_m.re_out)), 11);
    tick();

    // clear with two beats in flight (output held), input that cycle dropped
    got.delete();
    bus_m.out_ready = 1'b0;
    drive_m(1'b1, 30, 3, 1'b0);
    tick();
    drive_m(1'b1, 40, 4, 1'b0);
    tick();
    drive_m(1'b1, 50, 5, 1'b0);
    clear_m = 1'b1;
    tick();
    clear_m = 1'b0;
    drive_m(1'b0, 0, 0, 1'b0);
    bus_m.out_ready = 1'b1;
    tick(); tick(); tick();
    chk("clear_no_output", got.size(), 0);
    chk("clear_valid",     int'(bus_m.out_valid), 0);

    // ovf_clr in the same cycle as an overflow transfer: set wins
    drive_m(1'b1, -100, 100, 1'b1);
    tick();
    drive_m(1'b0, 0, 0, 1'b0);
    tick();
    chk("race_ovf", int'(bus_m.ovf), 1);
    ovf_clr_m = 1'b1;
    tick();
    ovf_clr_m = 1'b0;
    chk("race_sticky", int'(sticky_m), 1);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
